// File: rtl/kernel_a_rr_sched.sv
// Round-robin scheduler sharing one fixed-latency kernel_A adder between NREQ lanes.
// Optional per-lane grant counters are enabled by defining KA_SCHED_STATS_EN.
module kernel_a_rr_sched #(
  parameter int STREAMW = 32,
  parameter int NREQ    = 2,
  parameter int KLAT    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*STREAMW-1:0]  req_in1,
  input  logic [NREQ*STREAMW-1:0]  req_in2,
  output logic [NREQ-1:0]          res_valid,
  input  logic [NREQ-1:0]          res_ready,
  output logic [NREQ*STREAMW-1:0]  res_data,
  output logic                     k_ivalid,
  input  logic                     k_iready,
  output logic                     k_oready,
  output logic [STREAMW-1:0]       k_in1,
  output logic [STREAMW-1:0]       k_in2,
  input  logic                     k_ovalid,
  input  logic [STREAMW-1:0]       k_out,
`ifdef KA_SCHED_STATS_EN
  output logic [NREQ*32-1:0]       grant_cnt,
`endif
  output logic                     proto_err
);

  localparam int LW = $clog2(NREQ);

  logic [LW-1:0]      ptr_q, ptr_d;
  logic [KLAT-1:0]    tag_v_q, tag_v_d;
  logic [LW-1:0]      tag_l_q [KLAT];
  logic [LW-1:0]      tag_l_d [KLAT];
  logic [STREAMW-1:0] slot_q [NREQ];
  logic [STREAMW-1:0] slot_d [NREQ];
  logic [NREQ-1:0]    full_q, full_d;
  logic [STREAMW-1:0] kin1_q, kin1_d, kin2_q, kin2_d;
  logic               oready_q, oready_d;
  logic               err_q, err_d;

  logic [NREQ-1:0]    in_flight;
  logic [NREQ-1:0]    elig;
  logic               grant;
  logic [LW-1:0]      gidx;
  logic [LW-1:0]      cand;
  logic               cap;
  logic               mismatch;
  logic [LW-1:0]      cap_lane;

  // A lane with a tag anywhere in the pipeline already owns its slot credit.
  always_comb begin
    in_flight = '0;
    for (int s = 0; s < KLAT; s++) begin
      if (tag_v_q[s]) in_flight[tag_l_q[s]] = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign elig[gi] = req_valid[gi] && (!full_q[gi] || res_ready[gi]) && !in_flight[gi];
      assign res_data[gi*STREAMW +: STREAMW] = slot_q[gi];
    end
  endgenerate

  always_comb begin
    grant = 1'b0;
    gidx  = ptr_q;
    cand  = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      cand = LW'((int'(ptr_q) + k) % NREQ);
      if (!grant && elig[cand] && k_iready && !rst) begin
        grant = 1'b1;
        gidx  = cand;
      end
    end
  end

  assign cap      = tag_v_q[KLAT-1] && k_ovalid;
  assign mismatch = tag_v_q[KLAT-1] != k_ovalid;
  assign cap_lane = tag_l_q[KLAT-1];

  always_comb begin
    req_ready = '0;
    k_ivalid  = grant;
    k_in1     = kin1_q;
    k_in2     = kin2_q;
    ptr_d     = ptr_q;
    kin1_d    = kin1_q;
    kin2_d    = kin2_q;
    if (grant) begin
      req_ready[gidx] = 1'b1;
      k_in1  = req_in1[int'(gidx)*STREAMW +: STREAMW];
      k_in2  = req_in2[int'(gidx)*STREAMW +: STREAMW];
      kin1_d = k_in1;
      kin2_d = k_in2;
      ptr_d  = gidx;
    end

    tag_v_d[0] = grant;
    tag_l_d[0] = gidx;
    for (int s = 1; s < KLAT; s++) begin
      tag_v_d[s] = tag_v_q[s-1];
      tag_l_d[s] = tag_l_q[s-1];
    end

    // Capture wins over a same-cycle drain so a refilled slot stays full.
    full_d = full_q & ~res_ready;
    slot_d = slot_q;
    if (cap) begin
      slot_d[cap_lane] = k_out;
      full_d[cap_lane] = 1'b1;
    end

    err_d    = err_q | mismatch;
    oready_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q    <= LW'(NREQ-1);
      tag_v_q  <= '0;
      for (int s = 0; s < KLAT; s++) tag_l_q[s] <= '0;
      for (int i = 0; i < NREQ; i++) slot_q[i] <= '0;
      full_q   <= '0;
      kin1_q   <= '0;
      kin2_q   <= '0;
      oready_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      tag_v_q  <= tag_v_d;
      tag_l_q  <= tag_l_d;
      slot_q   <= slot_d;
      full_q   <= full_d;
      kin1_q   <= kin1_d;
      kin2_q   <= kin2_d;
      oready_q <= oready_d;
      err_q    <= err_d;
    end
  end

  assign res_valid = full_q;
  assign k_oready  = oready_q;
  assign proto_err = err_q;

`ifdef KA_SCHED_STATS_EN
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
      logic [31:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (grant && gidx == LW'(gi)) cnt_d = cnt_q + 32'd1;
      end
      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
      assign grant_cnt[gi*32 +: 32] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_kernel_a_rr_sched.sv
// Scoreboard bench for kernel_a_rr_sched with a one-cycle adder kernel model;
// checks grant_cnt too when KA_SCHED_STATS_EN is defined.
module tb_kernel_a_rr_sched;
  localparam int W = 32;
  localparam int N = 2;
  localparam int KL = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready, res_valid, res_ready;
  logic [N*W-1:0] req_in1, req_in2, res_data;
  logic           k_ivalid, k_iready, k_oready, k_ovalid, proto_err;
  logic [W-1:0]   k_in1, k_in2, k_out;
`ifdef KA_SCHED_STATS_EN
  logic [N*32-1:0] grant_cnt;
`endif

  kernel_a_rr_sched #(.STREAMW(W), .NREQ(N), .KLAT(KL)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .k_ivalid(k_ivalid), .k_iready(k_iready), .k_oready(k_oready),
    .k_in1(k_in1), .k_in2(k_in2), .k_ovalid(k_ovalid), .k_out(k_out),
`ifdef KA_SCHED_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .proto_err(proto_err)
  );

  // One-cycle adder kernel; inj forces a spurious ovalid.
  logic         kov_q, inj;
  logic [W-1:0] kout_q;
  always @(posedge clk) begin
    if (rst) begin
      kov_q  <= 1'b0;
      kout_q <= '0;
    end else begin
      kov_q <= k_ivalid && k_iready;
      if (k_ivalid && k_iready) kout_q <= k_in1 + k_in2;
    end
  end
  assign k_ovalid = kov_q | inj;
  assign k_out    = inj ? 32'hDEADBEEF : kout_q;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [W-1:0] src_a [N][$];
  logic [W-1:0] src_b [N][$];
  logic [W-1:0] exp_q [N][$];
  int gl_lane[$];
  int gl_cyc[$];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit pending();
    for (int l = 0; l < N; l++)
      if (src_a[l].size() > 0 || exp_q[l].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int l, input int a, input int b);
    src_a[l].push_back(W'(a));
    src_b[l].push_back(W'(b));
  endtask

  task automatic wait_drain(input string nm);
    int k = 0;
    while (pending() && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (pending()) check(nm, 1, 0);
    @(posedge clk); #3;
  endtask

  task automatic wait_valid(input int l, input string nm);
    int k = 0;
    @(negedge clk);
    while (!res_valid[l] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid[l]) check(nm, 0, 1);
  endtask

  // Source driver: presents queue heads, moves accepted items to the scoreboard.
  initial begin
    logic [N-1:0] acc;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int l = 0; l < N; l++) begin
        if (acc[l]) begin
          exp_q[l].push_back(src_a[l][0] + src_b[l][0]);
          $display("issue  lane %0d: %0d + %0d", l, src_a[l][0], src_b[l][0]);
          void'(src_a[l].pop_front());
          void'(src_b[l].pop_front());
        end
        if (src_a[l].size() > 0) begin
          req_valid[l]         = 1'b1;
          req_in1[l*W +: W]    = src_a[l][0];
          req_in2[l*W +: W]    = src_b[l][0];
        end else begin
          req_valid[l] = 1'b0;
        end
      end
    end
  end

  // Monitor: grant legality, grant log, and result scoreboard.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        check("grant_onehot", int'($countones(req_ready) <= 1), 1);
        check("ivalid_vs_grant", int'(k_ivalid), int'(|req_ready));
        for (int l = 0; l < N; l++) begin
          if (req_ready[l]) begin
            gl_lane.push_back(l);
            gl_cyc.push_back(cyc);
            check("k_in1_operand", int'(k_in1), int'(req_in1[l*W +: W]));
            check("k_in2_operand", int'(k_in2), int'(req_in2[l*W +: W]));
          end
          if (res_valid[l] && res_ready[l]) begin
            if (exp_q[l].size() == 0) begin
              check("unexpected_result", 1, 0);
            end else begin
              e = exp_q[l].pop_front();
              $display("result lane %0d: %0d (expected %0d)", l, res_data[l*W +: W], e);
              check("result_data", int'(res_data[l*W +: W]), int'(e));
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gc, rc, n0, n1;
    rst       = 1'b1;
    inj       = 1'b0;
    k_iready  = 1'b1;
    res_ready = '1;
    // Alternation stream queued during reset: must not be granted until release.
    for (int i = 0; i < 10; i++) begin
      push(0, i, 1);
      push(1, i, 100);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_res_valid", int'(res_valid), 0);
    check("rst_k_ivalid", int'(k_ivalid), 0);
    check("rst_k_oready", int'(k_oready), 0);
    check("rst_proto_err", int'(proto_err), 0);
    check("rst_res_data0", int'(res_data[W-1:0]), 0);
    check("rst_res_data1", int'(res_data[2*W-1:W]), 0);
`ifdef KA_SCHED_STATS_EN
    check("rst_grant_cnt0", int'(grant_cnt[31:0]), 0);
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // Alternation: 0,1,0,1 on consecutive cycles.
    wait_drain("alt_drain_timeout");
    check("alt_grant_count", gl_lane.size(), 20);
    for (int i = 0; i < 20 && i < gl_lane.size(); i++) begin
      check("alt_grant_lane", gl_lane[i], i % 2);
      if (i > 0) check("alt_grant_back_to_back", gl_cyc[i] - gl_cyc[i-1], 1);
    end
    check("k_oready_after_rst", int'(k_oready), 1);
`ifdef KA_SCHED_STATS_EN
    check("stats_lane0", int'(grant_cnt[31:0]), 10);
    check("stats_lane1", int'(grant_cnt[63:32]), 10);
`endif

    // Single lane: 3 + 4, result KLAT+1 cycles after grant.
    push(0, 3, 4);
    gc = -100;
    rc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready[0] && gc < 0) gc = cyc;
      if (res_valid[0]) begin
        rc = cyc;
        check("single_data", int'(res_data[W-1:0]), 7);
        break;
      end
    end
    check("single_latency", rc - gc, KL + 1);
    wait_drain("single_drain_timeout");

    // Fairness after idle: lane 1 last, then both -> lane 0.
    push(1, 1, 1);
    wait_drain("fair_a_timeout");
    gl_lane.delete(); gl_cyc.delete();
    push(0, 2, 2);
    push(1, 3, 3);
    wait_drain("fair_b_timeout");
    check("fair_count", gl_lane.size(), 2);
    if (gl_lane.size() >= 2) begin
      check("fair_first", gl_lane[0], 0);
      check("fair_second", gl_lane[1], 1);
    end

    // Backpressure on lane 1 with its slot full.
    res_ready[1] = 1'b0;
    push(1, 7, 8);
    wait_valid(1, "bp_fill_timeout");
    for (int i = 0; i < 6; i++) push(0, i, i + 20);
    push(1, 50, 1);
    push(1, 51, 1);
    gl_lane.delete(); gl_cyc.delete();
    repeat (5) begin
      @(negedge clk);
      check("bp_hold_valid", int'(res_valid[1]), 1);
      check("bp_hold_data", int'(res_data[2*W-1:W]), 15);
    end
    n0 = 0; n1 = 0;
    foreach (gl_lane[i]) begin
      if (gl_lane[i] == 0) n0++; else n1++;
    end
    check("bp_lane1_grants", n1, 0);
    check("bp_lane0_grants", n0, 3);
    for (int i = 1; i < gl_lane.size(); i++) check("bp_lane0_gap", gl_cyc[i] - gl_cyc[i-1], 2);
    @(posedge clk); #3;
    res_ready[1] = 1'b1;
    wait_drain("bp_release_timeout");
    n1 = 0;
    foreach (gl_lane[i]) if (gl_lane[i] == 1) n1++;
    check("bp_lane1_resumed", n1, 2);

    // Reset the cycle after a grant to lane 0.
    gl_lane.delete(); gl_cyc.delete();
    push(0, 5, 6);
    for (int k = 0; k < 20 && gl_lane.size() == 0; k++) @(negedge clk);
    check("rmf_grant_seen", gl_lane.size(), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q[0].delete();
    repeat (6) begin
      @(negedge clk);
      check("rmf_no_res_valid", int'(res_valid), 0);
    end
    check("rmf_proto_err", int'(proto_err), 0);
    gl_lane.delete(); gl_cyc.delete();
    push(0, 1, 2);
    push(1, 3, 4);
    wait_drain("rmf_ptr_timeout");
    if (gl_lane.size() > 0) check("rmf_ptr_lane0_first", gl_lane[0], 0);
    else check("rmf_ptr_lane0_first", -1, 0);

    // Error injection with lane 0 slot held full.
    res_ready[0] = 1'b0;
    push(0, 10, 20);
    wait_valid(0, "err_fill_timeout");
    check("err_before", int'(proto_err), 0);
    @(posedge clk); #3;
    inj = 1'b1;
    @(posedge clk); #1;
    inj = 1'b0;
    @(negedge clk);
    check("err_set", int'(proto_err), 1);
    check("err_slot0_valid", int'(res_valid[0]), 1);
    check("err_slot0_data", int'(res_data[W-1:0]), 30);
    check("err_slot1_valid", int'(res_valid[1]), 0);
    repeat (3) begin
      @(negedge clk);
      check("err_sticky", int'(proto_err), 1);
    end
    @(posedge clk); #3;
    res_ready[0] = 1'b1;
    wait_drain("err_drain_timeout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
